// File: rtl/contador_pkg.sv
// Package: contador_pkg
// Shared definitions for the modulo-N counter used by the game datapath:
// the default modulus (one step per board cell) and the pure arithmetic
// helpers for load clamping and next-count calculation.
// Values are passed as 32-bit unsigned integers. Callers truncate the
// results back to their own data width.

package contador_pkg;

    // Default modulus: nine board cells, counting 0..8.
    localparam int DEFAULT_MOD_N = 9;

    // Result of one counting step.
    // bound is set when the step hit a limit, whether it wrapped or saturated.
    typedef struct packed {
        logic        bound;
        logic [31:0] value;
    } count_res_t;

    // Out-of-range load values are clamped to the top state so the count
    // never leaves 0..mod_n-1.
    function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                               input logic [31:0] mod_n);
        return (val < mod_n) ? val : mod_n - 32'd1;
    endfunction

    // Next count for one step in the given direction.
    // Both bounds are compared explicitly, so the result never depends on
    // 2^W overflow.
    function automatic count_res_t next_count(input logic [31:0] cur,
                                              input logic        up,
                                              input logic [31:0] mod_n,
                                              input logic        sat);
        count_res_t r;
        r.bound = 1'b0;
        r.value = cur;
        if (up) begin
            if (cur == mod_n - 32'd1) begin
                r.bound = 1'b1;
                r.value = sat ? cur : 32'd0;
            end else begin
                r.value = cur + 32'd1;
            end
        end else begin
            if (cur == 32'd0) begin
                r.bound = 1'b1;
                r.value = sat ? cur : mod_n - 32'd1;
            end else begin
                r.value = cur - 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_mod_divisor_tick.sv
// Module: divisor_tick
// Prescaler for contador_mod. It counts enabled cycles and raises step on
// the PRESCALE-th one. step is combinational so the counter can act on it
// in the same cycle.
// Ports:
//   clk   in   clock
//   rst   in   synchronous reset, active-high; phase returns to 0
//   clr   in   synchronous phase clear (counter clear or load)
//   en    in   count enable; phase holds while low
//   step  out  en && phase == PRESCALE-1

module divisor_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // A step on every enabled cycle needs no phase state.
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clr};
            assign step      = en;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE) + 1;
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase;

            assign step = en && (phase == LAST);

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    phase <= '0;
                end else if (en) begin
                    phase <= step ? '0 : phase + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/contador_mod.sv
// Module: contador_mod
// Parametrised modulo-N turn/cell/timer counter. It has enable, up/down
// direction, synchronous clear and clamped parallel load, a built-in
// prescaler, and either wrap or saturate behaviour at the bounds.
// All outputs are registered.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high
//   en        in   count enable (prescaler and counter hold while low)
//   up        in   1 = increment, 0 = decrement (used on step cycles)
//   clear     in   synchronous clear to 0
//   load      in   synchronous parallel load (clamped to MOD_N-1)
//   load_val  in   value to load
//   data      out  current count
//   tick      out  1-cycle pulse: data holds a freshly stepped value
//   tc        out  1-cycle pulse: the last step hit a bound

module contador_mod
    import contador_pkg::*;
#(
    parameter int MOD_N    = DEFAULT_MOD_N,
    parameter int W        = $clog2(MOD_N),
    parameter int PRESCALE = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] data,
    output logic         tick,
    output logic         tc
);

    generate
        if (MOD_N < 2) begin : g_bad_mod_n
            $error("contador_mod: MOD_N must be >= 2");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("contador_mod: PRESCALE must be >= 1");
        end
        if (W < $clog2(MOD_N)) begin : g_bad_width
            $error("contador_mod: W must be >= $clog2(MOD_N)");
        end
    endgenerate

    logic       step;
    count_res_t nxt;
    logic [W-1:0] load_clamped;

    // Clear and load both restart the prescaler interval.
    divisor_tick #(
        .PRESCALE (PRESCALE)
    ) u_divisor (
        .clk  (clk),
        .rst  (rst),
        .clr  (clear | load),
        .en   (en),
        .step (step)
    );

    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
        nxt          = '0;
        load_clamped = '0;
        nxt          = next_count(32'(data), up, 32'(MOD_N), SATURATE);
        load_clamped = W'(clamp_load(32'(load_val), 32'(MOD_N)));
    end

    // Priority: rst > clear > load > step.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here make each register sample the values from before the edge, whatever the statement order.
        if (rst) begin
            data <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (clear) begin
            data <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (load) begin
            data <= load_clamped;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (step) begin
            data <= W'(nxt.value);
            tick <= 1'b1;
            tc   <= nxt.bound;
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contador_mod.sv
// Testbench for contador_mod. It drives three instances:
//   0: MOD_N=9, PRESCALE=1, wrap
//   1: MOD_N=9, PRESCALE=1, saturate
//   2: MOD_N=9, PRESCALE=3, wrap
// Each vector gives one instance's inputs for one edge together with the
// data/tick/tc that instance must show after that edge.

module tb_contador_mod;

    typedef struct {
        int         d;
        logic       rst, en, up, clr, ld;
        logic [3:0] lv;
        logic [3:0] data;
        logic       tick, tc;
        string      name;
    } vec_t;

    typedef struct {
        int         d;
        logic [3:0] data;
        logic       tick, tc;
        string      name;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst_v   [3];
    logic       en_v    [3];
    logic       up_v    [3];
    logic       clr_v   [3];
    logic       ld_v    [3];
    logic [3:0] lv_v    [3];
    logic [3:0] data_v  [3];
    logic       tick_v  [3];
    logic       tc_v    [3];

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[$];
    sb_t  exp_q[$];

    always #5 clk = ~clk;

    contador_mod #(.MOD_N(9), .W(4), .PRESCALE(1), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .up(up_v[0]), .clear(clr_v[0]),
        .load(ld_v[0]), .load_val(lv_v[0]), .data(data_v[0]), .tick(tick_v[0]), .tc(tc_v[0]));

    contador_mod #(.MOD_N(9), .W(4), .PRESCALE(1), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .up(up_v[1]), .clear(clr_v[1]),
        .load(ld_v[1]), .load_val(lv_v[1]), .data(data_v[1]), .tick(tick_v[1]), .tc(tc_v[1]));

    contador_mod #(.MOD_N(9), .W(4), .PRESCALE(3), .SATURATE(1'b0)) dut_pre (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .up(up_v[2]), .clear(clr_v[2]),
        .load(ld_v[2]), .load_val(lv_v[2]), .data(data_v[2]), .tick(tick_v[2]), .tc(tc_v[2]));

    function automatic vec_t mk(input int d, input logic rst, input logic en, input logic up,
                                input logic clr, input logic ld, input logic [3:0] lv,
                                input logic [3:0] data, input logic tick, input logic tc,
                                input string name);
        vec_t v;
        v.d = d; v.rst = rst; v.en = en; v.up = up; v.clr = clr; v.ld = ld; v.lv = lv;
        v.data = data; v.tick = tick; v.tc = tc; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got data=%0d tick=%0b tc=%0b, expected data=%0d tick=%0b tc=%0b",
                     name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Drive one vector before the edge and queue its expectation.
    // The expectation is popped and compared 1 ns after the edge.
    task automatic drive(input vec_t v);
        sb_t e;
        sb_t got;
        @(negedge clk);
        rst_v[v.d] = v.rst; en_v[v.d] = v.en; up_v[v.d] = v.up;
        clr_v[v.d] = v.clr; ld_v[v.d] = v.ld; lv_v[v.d] = v.lv;
        e.d = v.d; e.data = v.data; e.tick = v.tick; e.tc = v.tc; e.name = v.name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check(got.name, {data_v[got.d], tick_v[got.d], tc_v[got.d]},
              {got.data, got.tick, got.tc});
    endtask

    task automatic run(input int d, input logic rst, input logic en, input logic up,
                       input logic clr, input logic ld, input logic [3:0] lv,
                       input logic [3:0] data, input logic tick, input logic tc,
                       input string name);
        drive(mk(d, rst, en, up, clr, ld, lv, data, tick, tc, name));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; en_v[i] = 1'b0; up_v[i] = 1'b0;
            clr_v[i] = 1'b0; ld_v[i] = 1'b0; lv_v[i] = 4'd0;
        end

        // Instance 0, wrap: reset, then count up through the wrap.
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, "wrap_reset"));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4'(k), 1, 0, $sformatf("wrap_up_%0d", k)));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4'd0, 1, 1, "wrap_up_to_0"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4'd1, 1, 0, "wrap_up_after"));
        // Load 0, then count down through the wrap.
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 4'd0, 0, 0, "load_0_over_step"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'd8, 1, 1, "down_wrap_to_8"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'd7, 1, 0, "down_7"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'd6, 1, 0, "down_6"));
        // Load handling and priorities.
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 5, 4'd5, 0, 0, "load_5"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 4'd5, 0, 0, "en_low_hold"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 12, 4'd8, 0, 0, "load_12_clamp"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 5, 4'd0, 0, 0, "clear_over_load"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4'd1, 1, 0, "step_after_clear"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 3, 4'd3, 0, 0, "load_3"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 7, 4'd0, 0, 0, "rst_over_load"));

        // Instance 1, saturate.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, "sat_reset"));
        vecs.push_back(mk(1, 0, 0, 1, 0, 1, 8, 4'd8, 0, 0, "sat_load_8"));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 4'd8, 1, 1, $sformatf("sat_hold_top_%0d", k)));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'd7, 1, 0, "sat_down_7"));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 4'd0, 0, 0, "sat_load_0"));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 4'd0, 1, 1, "sat_hold_bottom"));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0, 4'd1, 1, 0, "sat_up_1"));

        foreach (vecs[i]) drive(vecs[i]);

        // Instance 2, PRESCALE=3: one step every third enabled cycle.
        run(2, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, "pre_reset");
        run(2, 0, 1, 1, 0, 0, 0, 4'd0, 0, 0, "pre_ph1");
        run(2, 0, 1, 1, 0, 0, 0, 4'd0, 0, 0, "pre_ph2");
        run(2, 0, 1, 1, 0, 0, 0, 4'd1, 1, 0, "pre_step_1");
        run(2, 0, 1, 1, 0, 0, 0, 4'd1, 0, 0, "pre_ph1_again");
        // Freeze at phase 1 for five cycles.
        for (int k = 0; k < 5; k++)
            run(2, 0, 0, 1, 0, 0, 0, 4'd1, 0, 0, $sformatf("pre_frozen_%0d", k));
        run(2, 0, 1, 1, 0, 0, 0, 4'd1, 0, 0, "pre_resume_ph2");
        run(2, 0, 1, 1, 0, 0, 0, 4'd2, 1, 0, "pre_resume_step");
        // Advance to count 4 at phase 2, then reset.
        run(2, 0, 1, 1, 0, 0, 0, 4'd2, 0, 0, "pre_a1");
        run(2, 0, 1, 1, 0, 0, 0, 4'd2, 0, 0, "pre_a2");
        run(2, 0, 1, 1, 0, 0, 0, 4'd3, 1, 0, "pre_a3");
        run(2, 0, 1, 1, 0, 0, 0, 4'd3, 0, 0, "pre_a4");
        run(2, 0, 1, 1, 0, 0, 0, 4'd3, 0, 0, "pre_a5");
        run(2, 0, 1, 1, 0, 0, 0, 4'd4, 1, 0, "pre_a6");
        run(2, 0, 1, 1, 0, 0, 0, 4'd4, 0, 0, "pre_a7");
        run(2, 0, 1, 1, 0, 0, 0, 4'd4, 0, 0, "pre_a8_ph2");
        run(2, 1, 1, 1, 0, 0, 0, 4'd0, 0, 0, "pre_rst_mid");
        run(2, 0, 1, 1, 0, 0, 0, 4'd0, 0, 0, "pre_post_rst_1");
        run(2, 0, 1, 1, 0, 0, 0, 4'd0, 0, 0, "pre_post_rst_2");
        run(2, 0, 1, 1, 0, 0, 0, 4'd1, 1, 0, "pre_post_rst_step");
        // A clear partway through an interval restarts the phase.
        run(2, 0, 1, 1, 0, 0, 0, 4'd1, 0, 0, "pre_c_ph1");
        run(2, 0, 1, 1, 1, 0, 0, 4'd0, 0, 0, "pre_clear");
        run(2, 0, 1, 1, 0, 0, 0, 4'd0, 0, 0, "pre_c_1");
        run(2, 0, 1, 1, 0, 0, 0, 4'd0, 0, 0, "pre_c_2");
        run(2, 0, 1, 1, 0, 0, 0, 4'd1, 1, 0, "pre_c_step");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
